regfile_access_sequencer: RTL and testbench
===========================================

Name: regfile_access_sequencer

Overview:
Initiator side of the 8x16 register-file interface: accepts one instruction at a time over a valid/ready handshake and drives the register file's two read ports and its single write port. A small FSM reads up to two operands, computes a 16-bit result with an internal ALU, and commits the result with a clean write strobe. The write strobe is edge-sensitive: the register file captures data on the rising edge of write_enable. The strobe is therefore preceded by a setup cycle and lasts exactly one clock. This block sits between the instruction source and the register file in the datapath.

Parameters:
DATA_W, 16, register and data width
ADDR_W, 3, register index width (2**ADDR_W registers)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction present
instr_ready  output  1  sequencer can accept (high only in IDLE)
instr_op  input  3  opcode: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MOV, 7 LDI
instr_rd  input  ADDR_W  destination register
instr_rs1  input  ADDR_W  source register 1
instr_rs2  input  ADDR_W  source register 2
instr_imm  input  DATA_W  immediate value (LDI only)
read_register1  output  ADDR_W  to register file read port 1
read_register2  output  ADDR_W  to register file read port 2
read_data1  input  DATA_W  from register file, combinational
read_data2  input  DATA_W  from register file, combinational
write_register  output  ADDR_W  to register file write address
write_data  output  DATA_W  to register file write data
write_enable  output  1  write strobe; register file latches on its rising edge
done  output  1  one-cycle pulse when an instruction retires
carry  output  1  carry/borrow flag
zero  output  1  result-zero flag

Behaviour:
- Reset (async, rst_n low): state goes to IDLE immediately. All registered outputs clear to 0: read_register1/2, write_register, write_data, write_enable, done, carry, zero. instr_ready = 1 while in IDLE.
- States: IDLE, READ, EXEC, SETUP, STROBE. All outputs are registered except instr_ready, which is (state==IDLE).
- IDLE: on instr_valid && instr_ready, latch op/rd/rs1/rs2/imm.
  - NOP: stay in IDLE; pulse done next cycle; no write.
  - LDI: go to SETUP.
  - All other opcodes: go to READ.
- READ: drive read_register1=rs1 and read_register2=rs2. Next state EXEC.
- EXEC: capture read_data1/2 from the addresses driven during READ and compute the result into a register.
  - ADD: {carry,res}=a+b.
  - SUB: res=a-b; carry=1 on borrow (a<b).
  - AND/OR/XOR: bitwise; carry held.
  - MOV: res=a; carry held.
  - All arithmetic is modulo 2**DATA_W.
  - Next state SETUP.
- SETUP: write_register=rd and write_data=result (imm for LDI); write_enable=0; zero=(result==0). Next state STROBE.
- STROBE: write_enable=1 for exactly this cycle; address and data unchanged; done=1. Next state IDLE, with write_enable back to 0.
- Latency (T = accept cycle):
  - ALU ops: write_enable and done high in T+4; instr_ready high again in T+5.
  - LDI: strobe in T+2.
  - NOP: done in T+1.
- write_register/write_data remain stable from SETUP until the next instruction's SETUP. Outside STROBE, write_enable never glitches high.
- rd equal to rs1 or rs2: operands are read before the write, so the old value is used.
- Back-to-back instructions: an instruction accepted after done sees the just-written value.
- instr_valid while busy: ignored, not latched. The source must hold the instruction until accepted.
- Reset during any state: the operation is abandoned and write_enable drops at once. A reset in SETUP or earlier leaves the register file unwritten.
- Flags: carry changes only on ADD/SUB. zero changes only on instructions that write (not NOP).

Decomposition:
- Shared package regfile_seq_pkg: opcode enum, FSM state enum, DATA_W/ADDR_W defaults.
- One sub-module rf_alu: combinational; inputs a, b, op; outputs res and carry. Instantiated once; the FSM and flag registers stay in the top module.

Test Plan:
- LDI r2,0x1234 at T -> write_register=2, write_data=0x1234 in T+1 with write_enable=0; write_enable=1 only in T+2; done in T+2; register file r2 reads 0x1234 afterwards.
- LDI r1,0xFFFF; LDI r3,0x0001; ADD r4,r1,r3 -> write_data=0x0000, carry=1, zero=1, strobe at T+4.
- SUB r5,r3,r1 (0x0001-0xFFFF) -> write_data=0x0002, carry=1, zero=0; then ADD r6,r3,r3 -> 0x0002, carry=0.
- instr_valid held high continuously with two ADDs -> instr_ready low during T+1..T+4; second ADD accepted at T+5; exactly two write_enable pulses.
- rst_n pulled low during EXEC of XOR r7,r1,r3 -> outputs 0 immediately; no write_enable pulse; r7 unchanged; after release, instr_ready=1 and LDI works.
- NOP -> done at T+1, write_enable never high, flags unchanged; XOR r6,r2,r2 -> write_data=0, zero=1, carry unchanged.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file access sequencer.
//   - default data / register-index widths
//   - instruction opcode encoding
//   - FSM state constants
package regfile_seq_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_MOV = 3'd6,
    OP_LDI = 3'd7
  } opcode_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_SETUP  = 3'd3;
  localparam logic [2:0] ST_STROBE = 3'd4;

endpackage

// File: rtl/regfile_access_sequencer_if.sv
// Bundle between instruction source, sequencer and register file.
//   master : sequencer side (accepts instructions, drives read/write ports)
//   slave  : environment side (instruction source plus register file)
interface regfile_access_sequencer_if #(
  parameter int DATA_W = regfile_seq_pkg::DEF_DATA_W,
  parameter int ADDR_W = regfile_seq_pkg::DEF_ADDR_W
);
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [ADDR_W-1:0] instr_rd;
  logic [ADDR_W-1:0] instr_rs1;
  logic [ADDR_W-1:0] instr_rs2;
  logic [DATA_W-1:0] instr_imm;
  logic [ADDR_W-1:0] read_register1;
  logic [ADDR_W-1:0] read_register2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [ADDR_W-1:0] write_register;
  logic [DATA_W-1:0] write_data;
  logic              write_enable;
  logic              done;
  logic              carry;
  logic              zero;

  modport master (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
    input  read_data1, read_data2,
    output instr_ready, read_register1, read_register2,
    output write_register, write_data, write_enable, done, carry, zero
  );

  modport slave (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
    output read_data1, read_data2,
    input  instr_ready, read_register1, read_register2,
    input  write_register, write_data, write_enable, done, carry, zero
  );
endinterface

// File: rtl/rf_alu.sv
// Combinational ALU for the sequencer.
//   a, b  : operands (register file read data)
//   op    : opcode
//   res   : result, modulo 2**DATA_W
//   carry : carry out for ADD, borrow (a < b) for SUB, 0 otherwise
module rf_alu
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  opcode_e           op,
  output logic [DATA_W-1:0] res,
  output logic              carry
);
  logic [DATA_W:0] ext;

  always_comb begin
    ext   = '0;
    res   = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        ext   = {1'b0, a} + {1'b0, b};
        res   = ext[DATA_W-1:0];
        carry = ext[DATA_W];
      end
      OP_SUB: begin
        // The extended MSB is set exactly when the subtraction borrows.
        ext   = {1'b0, a} - {1'b0, b};
        res   = ext[DATA_W-1:0];
        carry = ext[DATA_W];
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_MOV:  res = a;
      default: res = '0;
    endcase
  end
endmodule

// File: rtl/regfile_access_sequencer.sv
// Register-file access sequencer: takes one instruction at a time over a
// valid/ready handshake, reads up to two operands, computes a result and
// commits it with a write strobe that is preceded by a one-cycle setup phase
// and lasts exactly one clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : instruction handshake, register-file read/write ports, flags
module regfile_access_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  regfile_access_sequencer_if.master   bus
);
  logic [2:0]        state;
  opcode_e           op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] rr1_q;
  logic [ADDR_W-1:0] rr2_q;
  logic [ADDR_W-1:0] wreg_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              done_q;
  logic              carry_q;
  logic              zero_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;
  opcode_e           op_in;

  assign op_in           = opcode_e'(bus.instr_op);
  assign bus.instr_ready = (state == ST_IDLE);

  // Read addresses are held from READ through EXEC, so read_data reflects
  // the operands during EXEC and the ALU output is captured at its end.
  rf_alu #(.DATA_W(DATA_W)) u_alu (
    .a     (bus.read_data1),
    .b     (bus.read_data2),
    .op    (op_q),
    .res   (alu_res),
    .carry (alu_carry)
  );

  // Instruction latch: plain data, no reset needed.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && bus.instr_valid) begin
      op_q <= op_in;
      rd_q <= bus.instr_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      rr1_q   <= '0;
      rr2_q   <= '0;
      wreg_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        // ---- IDLE: accept ----
        ST_IDLE: begin
          if (bus.instr_valid) begin
            case (op_in)
              OP_NOP: done_q <= 1'b1;
              OP_LDI: begin
                // LDI needs no operands: go straight to the setup phase.
                wreg_q  <= bus.instr_rd;
                wdata_q <= bus.instr_imm;
                zero_q  <= (bus.instr_imm == '0);
                state   <= ST_SETUP;
              end
              default: begin
                rr1_q <= bus.instr_rs1;
                rr2_q <= bus.instr_rs2;
                state <= ST_READ;
              end
            endcase
          end
        end
        // ---- READ: addresses on the read ports ----
        ST_READ: state <= ST_EXEC;
        // ---- EXEC: capture ALU result, present it for setup ----
        ST_EXEC: begin
          wreg_q  <= rd_q;
          wdata_q <= alu_res;
          zero_q  <= (alu_res == '0);
          if (op_q == OP_ADD || op_q == OP_SUB) carry_q <= alu_carry;
          state   <= ST_SETUP;
        end
        // ---- SETUP: address/data stable, strobe low ----
        ST_SETUP: begin
          we_q   <= 1'b1;
          done_q <= 1'b1;
          state  <= ST_STROBE;
        end
        // ---- STROBE: single-cycle write pulse ----
        ST_STROBE: begin
          we_q  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          we_q  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.read_register1 = rr1_q;
  assign bus.read_register2 = rr2_q;
  assign bus.write_register = wreg_q;
  assign bus.write_data     = wdata_q;
  assign bus.write_enable   = we_q;
  assign bus.done           = done_q;
  assign bus.carry          = carry_q;
  assign bus.zero           = zero_q;
endmodule

// File: tb/tb_regfile_access_sequencer.sv
module tb_regfile_access_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_access_sequencer_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  regfile_access_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register file: combinational reads, captures on the write strobe edge.
  logic [15:0] rf [0:7] = '{default: 16'h0000};
  int we_pulses = 0;
  assign bus.read_data1 = rf[bus.read_register1];
  assign bus.read_data2 = rf[bus.read_register2];
  always @(posedge bus.write_enable) begin
    rf[bus.write_register] <= bus.write_data;
    we_pulses <= we_pulses + 1;
  end

  int total = 0;
  int bad = 0;

  // Reference architectural state.
  logic [15:0] ref_rf [0:7] = '{default: 16'h0000};
  logic ref_c = 1'b0;
  logic ref_z = 1'b0;
  logic [15:0] exp_res;
  logic exp_wr;
  int exp_lat;
  int exp_busy;

  // Per-cycle observations, index k = cycle T+k after acceptance.
  logic [6:1] obs_we, obs_done, obs_ready;
  logic [15:0] obs_wd [1:6];
  logic [2:0] obs_wr [1:6];
  logic obs_c [1:6];
  logic obs_z [1:6];
  int pulses_before, pulses_after;

  task automatic model(input int op, input int rd, input int rs1, input int rs2, input logic [15:0] imm);
    logic [15:0] a, b;
    int s;
    a = ref_rf[rs1];
    b = ref_rf[rs2];
    exp_wr   = (op != 0);
    exp_lat  = (op == 0) ? 1 : (op == 7) ? 2 : 4;
    exp_busy = (op == 0) ? 0 : exp_lat;
    exp_res  = 16'h0000;
    case (op)
      1: begin s = int'(a) + int'(b); exp_res = s[15:0]; ref_c = (s > 65535); end
      2: begin exp_res = a - b; ref_c = (a < b); end
      3: exp_res = a & b;
      4: exp_res = a | b;
      5: exp_res = a ^ b;
      6: exp_res = a;
      7: exp_res = imm;
      default: exp_res = 16'h0000;
    endcase
    if (exp_wr) begin
      ref_z = (exp_res == 16'h0000);
      ref_rf[rd] = exp_res;
    end
  endtask

  // Present one instruction, wait for acceptance, record six cycles.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [15:0] imm);
    int guard;
    guard = 0;
    bus.instr_valid = 1'b1;
    bus.instr_op = op;
    bus.instr_rd = rd;
    bus.instr_rs1 = rs1;
    bus.instr_rs2 = rs2;
    bus.instr_imm = imm;
    #1;
    while (bus.instr_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      total++; bad++;
      $display("FAIL accept_timeout ready=%b required=1", bus.instr_ready);
    end
    pulses_before = we_pulses;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      obs_we[k] = bus.write_enable;
      obs_done[k] = bus.done;
      obs_ready[k] = bus.instr_ready;
      obs_wd[k] = bus.write_data;
      obs_wr[k] = bus.write_register;
      obs_c[k] = bus.carry;
      obs_z[k] = bus.zero;
    end
    pulses_after = we_pulses;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({bus.read_register1, bus.read_register2, bus.write_register, bus.write_data,
         bus.write_enable, bus.done, bus.carry, bus.zero} !== 30'd0) begin
      bad++; $display("FAIL reset_outputs got=%h required=0", {bus.read_register1, bus.read_register2,
        bus.write_register, bus.write_data, bus.write_enable, bus.done, bus.carry, bus.zero});
    end
    total++;
    if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b required=1", bus.instr_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.instr_ready !== 1'b1 || bus.write_enable !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle ready=%b we=%b required ready=1 we=0", bus.instr_ready, bus.write_enable);
    end
  endtask

  task automatic test_ldi();
    issue(3'd7, 3'd2, 3'd0, 3'd0, 16'h1234);
    model(7, 2, 0, 0, 16'h1234);
    total++;
    if (obs_wr[1] !== 3'd2 || obs_wd[1] !== 16'h1234 || obs_we[1] !== 1'b0) begin
      bad++; $display("FAIL ldi_setup wr=%0d wd=%h we=%b required wr=2 wd=1234 we=0", obs_wr[1], obs_wd[1], obs_we[1]);
    end
    total++;
    if (obs_we !== 6'b000010) begin bad++; $display("FAIL ldi_strobe we=%b required=000010", obs_we); end
    total++;
    if (obs_done !== 6'b000010) begin bad++; $display("FAIL ldi_done done=%b required=000010", obs_done); end
    total++;
    if (rf[2] !== 16'h1234) begin bad++; $display("FAIL ldi_rf r2=%h required=1234", rf[2]); end
  endtask

  task automatic test_flags();
    issue(3'd7, 3'd1, 3'd0, 3'd0, 16'hFFFF); model(7, 1, 0, 0, 16'hFFFF);
    issue(3'd7, 3'd3, 3'd0, 3'd0, 16'h0001); model(7, 3, 0, 0, 16'h0001);
    issue(3'd1, 3'd4, 3'd1, 3'd3, 16'h0000); model(1, 4, 1, 3, 16'h0000);
    total++;
    if (obs_wd[4] !== 16'h0000 || obs_c[4] !== 1'b1 || obs_z[4] !== 1'b1) begin
      bad++; $display("FAIL add_wrap wd=%h c=%b z=%b required wd=0000 c=1 z=1", obs_wd[4], obs_c[4], obs_z[4]);
    end
    total++;
    if (obs_we !== 6'b001000 || obs_done !== 6'b001000) begin
      bad++; $display("FAIL add_latency we=%b done=%b required=001000", obs_we, obs_done);
    end
    issue(3'd2, 3'd5, 3'd3, 3'd1, 16'h0000); model(2, 5, 3, 1, 16'h0000);
    total++;
    if (obs_wd[4] !== 16'h0002 || obs_c[4] !== 1'b1 || obs_z[4] !== 1'b0) begin
      bad++; $display("FAIL sub_borrow wd=%h c=%b z=%b required wd=0002 c=1 z=0", obs_wd[4], obs_c[4], obs_z[4]);
    end
    issue(3'd1, 3'd6, 3'd3, 3'd3, 16'h0000); model(1, 6, 3, 3, 16'h0000);
    total++;
    if (obs_wd[4] !== 16'h0002 || obs_c[4] !== 1'b0) begin
      bad++; $display("FAIL add_small wd=%h c=%b required wd=0002 c=0", obs_wd[4], obs_c[4]);
    end
  endtask

  task automatic test_nop();
    issue(3'd1, 3'd0, 3'd1, 3'd1, 16'h0000); model(1, 0, 1, 1, 16'h0000);
    issue(3'd0, 3'd5, 3'd1, 3'd2, 16'hABCD); model(0, 5, 1, 2, 16'hABCD);
    total++;
    if (obs_done !== 6'b000001) begin bad++; $display("FAIL nop_done done=%b required=000001", obs_done); end
    total++;
    if (obs_we !== 6'b000000 || pulses_after != pulses_before) begin
      bad++; $display("FAIL nop_nowrite we=%b pulses=%0d required we=000000 pulses=0", obs_we, pulses_after - pulses_before);
    end
    total++;
    if (obs_c[6] !== 1'b1 || obs_z[6] !== 1'b0) begin
      bad++; $display("FAIL nop_flags c=%b z=%b required c=1 z=0", obs_c[6], obs_z[6]);
    end
    issue(3'd5, 3'd6, 3'd2, 3'd2, 16'h0000); model(5, 6, 2, 2, 16'h0000);
    total++;
    if (obs_wd[4] !== 16'h0000 || obs_z[4] !== 1'b1 || obs_c[4] !== 1'b1) begin
      bad++; $display("FAIL xor_self wd=%h z=%b c=%b required wd=0000 z=1 c=1", obs_wd[4], obs_z[4], obs_c[4]);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:1] rdy, we;
    logic [15:0] wd9;
    logic [15:0] first_res;
    int base;
    model(1, 0, 1, 3, 16'h0000);
    first_res = exp_res;
    model(1, 2, 0, 0, 16'h0000);
    base = we_pulses;
    bus.instr_valid = 1'b1; bus.instr_op = 3'd1; bus.instr_rd = 3'd0;
    bus.instr_rs1 = 3'd1; bus.instr_rs2 = 3'd3; bus.instr_imm = 16'h0000;
    @(posedge clk);
    #1 bus.instr_rd = 3'd2; bus.instr_rs1 = 3'd0; bus.instr_rs2 = 3'd0;
    wd9 = 16'hxxxx;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      rdy[k] = bus.instr_ready;
      we[k] = bus.write_enable;
      if (k == 9) wd9 = bus.write_data;
      if (k == 6) bus.instr_valid = 1'b0;
    end
    total++;
    if (rdy[6:1] !== 6'b010000) begin bad++; $display("FAIL b2b_ready ready=%b required=010000", rdy[6:1]); end
    total++;
    if (we !== 12'b0001_0000_1000) begin bad++; $display("FAIL b2b_strobes we=%b required=000100001000", we); end
    total++;
    if (we_pulses - base != 2) begin bad++; $display("FAIL b2b_pulses got=%0d required=2", we_pulses - base); end
    total++;
    if (wd9 !== exp_res || rf[2] !== exp_res || rf[0] !== first_res) begin
      bad++; $display("FAIL b2b_forward wd=%h r2=%h r0=%h required wd=r2=%h r0=%h", wd9, rf[2], rf[0], exp_res, first_res);
    end
  endtask

  task automatic test_reset_midop();
    logic [15:0] old7;
    int base;
    old7 = rf[7];
    base = we_pulses;
    bus.instr_valid = 1'b1; bus.instr_op = 3'd5; bus.instr_rd = 3'd7;
    bus.instr_rs1 = 3'd1; bus.instr_rs2 = 3'd3; bus.instr_imm = 16'h0000;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.read_register1, bus.read_register2, bus.write_register, bus.write_data,
         bus.write_enable, bus.done, bus.carry, bus.zero} !== 30'd0 || bus.instr_ready !== 1'b1) begin
      bad++; $display("FAIL midreset_clear rr1=%0d wd=%h we=%b ready=%b required all 0, ready=1",
        bus.read_register1, bus.write_data, bus.write_enable, bus.instr_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (we_pulses != base || rf[7] !== old7) begin
      bad++; $display("FAIL midreset_nowrite pulses=%0d r7=%h required pulses=0 r7=%h", we_pulses - base, rf[7], old7);
    end
    ref_c = 1'b0;
    ref_z = 1'b0;
    issue(3'd7, 3'd7, 3'd0, 3'd0, 16'hBEEF); model(7, 7, 0, 0, 16'hBEEF);
    total++;
    if (rf[7] !== 16'hBEEF || obs_we !== 6'b000010) begin
      bad++; $display("FAIL midreset_recover r7=%h we=%b required r7=beef we=000010", rf[7], obs_we);
    end
  endtask

  task automatic test_random();
    int op, rd, rs1, rs2;
    logic [15:0] imm;
    logic [5:0] exp_we, exp_done, exp_ready, mask;
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 7);
      rd = $urandom_range(0, 7);
      rs1 = $urandom_range(0, 7);
      rs2 = $urandom_range(0, 7);
      imm = (n % 5 == 0) ? 16'h0000 : 16'($urandom);
      issue(3'(op), 3'(rd), 3'(rs1), 3'(rs2), imm);
      model(op, rd, rs1, rs2, imm);
      exp_done = 6'd1 << (exp_lat - 1);
      exp_we = exp_wr ? exp_done : 6'd0;
      mask = (6'd1 << exp_busy) - 6'd1;
      exp_ready = ~mask;
      total++;
      if (obs_we !== exp_we || obs_done !== exp_done || obs_ready !== exp_ready) begin
        bad++; $display("FAIL rnd_timing op=%0d we=%b done=%b ready=%b required we=%b done=%b ready=%b",
          op, obs_we, obs_done, obs_ready, exp_we, exp_done, exp_ready);
      end
      if (exp_wr) begin
        total++;
        if (obs_wd[exp_lat] !== exp_res || obs_wr[exp_lat] !== 3'(rd)) begin
          bad++; $display("FAIL rnd_write op=%0d wd=%h wr=%0d required wd=%h wr=%0d",
            op, obs_wd[exp_lat], obs_wr[exp_lat], exp_res, rd);
        end
        total++;
        if (obs_wd[exp_lat-1] !== obs_wd[exp_lat] || obs_wd[6] !== obs_wd[exp_lat] || obs_we[exp_lat-1] !== 1'b0) begin
          bad++; $display("FAIL rnd_stable op=%0d setup=%h strobe=%h after=%h required all %h",
            op, obs_wd[exp_lat-1], obs_wd[exp_lat], obs_wd[6], exp_res);
        end
      end
      total++;
      if (obs_c[6] !== ref_c || obs_z[6] !== ref_z) begin
        bad++; $display("FAIL rnd_flags op=%0d c=%b z=%b required c=%b z=%b", op, obs_c[6], obs_z[6], ref_c, ref_z);
      end
    end
    for (int r = 0; r < 8; r++) begin
      total++;
      if (rf[r] !== ref_rf[r]) begin
        bad++; $display("FAIL rnd_regfile r%0d=%h required=%h", r, rf[r], ref_rf[r]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_op = 3'd0;
    bus.instr_rd = 3'd0;
    bus.instr_rs1 = 3'd0;
    bus.instr_rs2 = 3'd0;
    bus.instr_imm = 16'h0000;
    @(negedge clk);
    test_reset();
    test_ldi();
    test_flags();
    test_nop();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
